// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Holds the RV32 load/store funct3 encodings, the FSM state type, and a
// helper that flags funct3 codes that are illegal for a given access
// direction.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    // Unsigned variants only make sense for loads; 011/110/111 are never valid.
    function automatic logic f3_illegal(input logic [2:0] funct3, input logic write);
        case (funct3)
            F3_B, F3_H, F3_W: f3_illegal = 1'b0;
            F3_BU, F3_HU:     f3_illegal = write;
            default:          f3_illegal = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering shared by the load and store paths.
// Ports:
//   addr_lo    in   2   byte offset within the word
//   funct3     in   3   access size / signedness
//   mem_word   in   32  word currently held in storage
//   wdata      in   32  store data, right-aligned
//   load_data  out  32  selected lane, sign- or zero-extended
//   store_word out  32  mem_word with the addressed lane(s) replaced by wdata
//   misalign   out  1   half access on an odd address or word access off a word boundary
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word,
    output logic        misalign
);

    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] wdata_rep;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        shifted   = mem_word >> {addr_lo, 3'b000};
        load_data = shifted;
        lane_mask = '0;
        wdata_rep = wdata;
        misalign  = 1'b0;

        case (funct3)
            F3_B: begin
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << {addr_lo, 3'b000};
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_BU: begin
                load_data = {24'h0, shifted[7:0]};
            end
            F3_H: begin
                load_data = {{16{shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << {addr_lo, 3'b000};
                wdata_rep = {2{wdata[15:0]}};
                misalign  = addr_lo[0];
            end
            F3_HU: begin
                load_data = {16'h0, shifted[15:0]};
                misalign  = addr_lo[0];
            end
            F3_W: begin
                load_data = mem_word;
                lane_mask = '1;
                misalign  = |addr_lo;
            end
            default: ;
        endcase

        // Replicating wdata across lanes lets one mask select the target lane.
        store_word = (mem_word & ~lane_mask) | (wdata_rep & lane_mask);
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the RV32 load/store path.
// Accepts one request per handshake, waits LATENCY cycles, then presents
// a response that is held until the consumer takes it.
// Ports:
//   clk, reset_n                 clock and asynchronous active-low reset
//   req_valid / req_ready        request handshake
//   req_write, req_addr,
//   req_wdata, req_funct3        request payload (store flag, byte address, data, size)
//   rsp_valid / rsp_ready        response handshake
//   rsp_rdata, rsp_err           extended load data (0 for stores/errors), error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    dmem_state_t      state;
    logic [CNT_W-1:0] cnt;

    logic             wr_q;
    logic [AW+1:0]    addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [2:0]       f3_q;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] store_word;
    logic             misalign;
    logic             req_err;
    logic             finish;

    // Address bits above the storage range are ignored: the array wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[WIDTH-1:AW+2];

    assign idx       = addr_q[AW+1:2];
    assign req_ready = (state == IDLE) && reset_n;
    assign req_err   = misalign || f3_illegal(f3_q, wr_q);
    assign finish    = (state == WAIT) && (cnt == '0);

    dmem_lane_align u_align (
        .addr_lo    (addr_q[1:0]),
        .funct3     (f3_q),
        .mem_word   (mem[idx]),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word),
        .misalign   (misalign)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_q    <= req_write;
                        addr_q  <= req_addr[AW+1:0];
                        wdata_q <= req_wdata;
                        f3_q    <= req_funct3;
                        cnt     <= CNT_W'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // Storage commit happens on this same edge in the memory block.
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= req_err;
                        rsp_rdata <= (req_err || wr_q) ? '0 : load_data;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; clearing it
    // would turn the RAM into a bank of resettable flops. A reset during WAIT
    // forces state to IDLE asynchronously, so a pending store never commits.
    always_ff @(posedge clk) begin
        if (finish && wr_q && !req_err) begin
            mem[idx] <= store_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY = 2).
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;

    dmem_responder #(.WIDTH(32), .DEPTH(1024), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full transaction; inputs change and outputs are sampled 1 time unit after posedge.
    task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output logic e,
                        output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        rd = rsp_rdata;
        e  = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h10, 32'h8000_00F1, F3_W, rd, e, lat);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sw_rsp: got err=%b rdata=%h expected err=0 rdata=0", e, rd); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL sw_latency: got %0d expected %0d", lat, LAT); end
        xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'h8000_00F1 || e !== 1'b0) begin errors++; $display("FAIL lw: got err=%b rdata=%h expected err=0 rdata=800000f1", e, rd); end
        checks++;
        if (lat != LAT) begin errors++; $display("FAIL lw_latency: got %0d expected %0d", lat, LAT); end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic e; int lat;
        xact(1'b0, 32'h10, 32'h0, F3_B, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_FFF1 || e !== 1'b0) begin errors++; $display("FAIL lb: got %h expected fffffff1", rd); end
        xact(1'b0, 32'h10, 32'h0, F3_BU, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_00F1 || e !== 1'b0) begin errors++; $display("FAIL lbu: got %h expected 000000f1", rd); end
        xact(1'b0, 32'h12, 32'h0, F3_H, rd, e, lat);
        checks++;
        if (rd !== 32'hFFFF_8000 || e !== 1'b0) begin errors++; $display("FAIL lh: got %h expected ffff8000", rd); end
        xact(1'b0, 32'h12, 32'h0, F3_HU, rd, e, lat);
        checks++;
        if (rd !== 32'h0000_8000 || e !== 1'b0) begin errors++; $display("FAIL lhu: got %h expected 00008000", rd); end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h10, 32'h1122_3344, F3_W, rd, e, lat);
        xact(1'b1, 32'h11, 32'h1234_56AB, F3_B, rd, e, lat);
        xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'h1122_AB44) begin errors++; $display("FAIL sb_merge: got %h expected 1122ab44", rd); end
        xact(1'b1, 32'h12, 32'hFFFF_BEEF, F3_H, rd, e, lat);
        xact(1'b0, 32'h10, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'hBEEF_AB44) begin errors++; $display("FAIL sh_merge: got %h expected beefab44", rd); end
        // Address above the array range wraps onto the same word.
        xact(1'b0, 32'h0000_1010, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'hBEEF_AB44) begin errors++; $display("FAIL wrap_lw: got %h expected beefab44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h0, 32'hCAFE_F00D, F3_W, rd, e, lat);
        xact(1'b0, 32'h2, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misalign: got err=%b rdata=%h expected err=1 rdata=0", e, rd); end
        xact(1'b1, 32'h1, 32'hFFFF_FFFF, F3_H, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL sh_misalign: got err=%b expected 1", e); end
        xact(1'b1, 32'h0, 32'h0000_0000, F3_BU, rd, e, lat);
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL store_bu: got err=%b expected 1", e); end
        xact(1'b0, 32'h0, 32'h0, 3'b011, rd, e, lat);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL illegal_f3: got err=%b rdata=%h expected err=1 rdata=0", e, rd); end
        xact(1'b0, 32'h0, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin errors++; $display("FAIL mem_unchanged: got %h expected cafef00d", rd); end
    endtask

    task automatic test_backpressure();
        int n;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_funct3 = F3_W;
        @(posedge clk); #1;
        // Keep a second request pending the whole time the first is in flight.
        req_addr = 32'h10;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rsp_valid) begin checks++; errors++; $display("FAIL bp_rsp_timeout: rsp_valid=%b required 1", rsp_valid); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE_F00D || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1 cafef00d 0", i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != LAT || rsp_rdata !== 32'hBEEF_AB44) begin errors++; $display("FAIL bp_second: got lat=%0d rdata=%h expected %0d beefab44", n, rsp_rdata, LAT); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic e; int lat;
        xact(1'b1, 32'h20, 32'h1234_5678, F3_W, rd, e, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555; req_funct3 = F3_W;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_in_reset: got ready=%b valid=%b expected 0 0", req_ready, rsp_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_after: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid); end
        xact(1'b0, 32'h20, 32'h0, F3_W, rd, e, lat);
        checks++;
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin errors++; $display("FAIL abort_lw: got %h expected 12345678", rd); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_load_ext();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
